// File: rtl/cla_carry_sum_pipe.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshakes on both ends.
// Define CLA_FLAGS_EN to produce registered carry-out and signed-overflow flags.
module cla_carry_sum_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NG = WIDTH / 4;

   logic             out_adv;
   logic             s1_adv;
   logic             s1_valid;

   logic [WIDTH-1:0] bb;
   logic [WIDTH-1:0] g_d;
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] x_d;
   logic [NG-1:0]    gg_d;
   logic [NG-1:0]    pg_d;

   logic [WIDTH-1:0] g_q;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] x_q;
   logic [NG-1:0]    gg_q;
   logic [NG-1:0]    pg_q;
   logic             c0_q;

   logic [NG:0]      gc;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] sum_d;
   logic [2*NG-1:0]  top_gp;
   logic             unused_bits;

   // Handshake: each register advances when its downstream slot is free or draining.
   assign out_adv  = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || out_adv;
   assign in_ready = s1_adv;

   // Stage 1: operand conditioning, per-bit g/p/x and per-nibble G/P.
   always_comb begin
      bb   = sub ? ~b : b;
      g_d  = a & bb;
      p_d  = a | bb;
      x_d  = a ^ bb;
      gg_d = '0;
      pg_d = '0;
      for (int unsigned k = 0; k < NG; k++) begin
         gg_d[k] = g_d[4*k+3]
                 | (p_d[4*k+3] & g_d[4*k+2])
                 | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                 | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
         pg_d[k] = &p_d[4*k +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         g_q      <= '0;
         p_q      <= '0;
         x_q      <= '0;
         gg_q     <= '0;
         pg_q     <= '0;
         c0_q     <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            g_q  <= g_d;
            p_q  <= p_d;
            x_q  <= x_d;
            gg_q <= gg_d;
            pg_q <= pg_d;
            c0_q <= sub;
         end
      end
   end

   // Stage 2: group carries by lookahead, then short ripple inside each nibble.
   always_comb begin
      gc     = '0;
      c      = '0;
      top_gp = '0;
      gc[0]  = c0_q;
      for (int unsigned k = 0; k < NG; k++) begin
         gc[k+1] = gg_q[k] | (pg_q[k] & gc[k]);
      end
      for (int unsigned k = 0; k < NG; k++) begin
         c[4*k] = gc[k];
         for (int unsigned j = 0; j < 3; j++) begin
            c[4*k+j+1] = g_q[4*k+j] | (p_q[4*k+j] & c[4*k+j]);
         end
         top_gp[2*k]   = g_q[4*k+3];
         top_gp[2*k+1] = p_q[4*k+3];
      end
      sum_d = x_q ^ c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         sum       <= '0;
      end else if (out_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum <= sum_d;
         end
      end
   end

`ifdef CLA_FLAGS_EN
   logic a_msb_q;
   logic bb_msb_q;
   logic ovf_d;

   // Overflow: operands share a sign that the result does not.
   assign ovf_d = (a_msb_q == bb_msb_q) && (sum_d[WIDTH-1] != a_msb_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         a_msb_q  <= 1'b0;
         bb_msb_q <= 1'b0;
      end else if (s1_adv && in_valid) begin
         a_msb_q  <= a[WIDTH-1];
         bb_msb_q <= bb[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (out_adv && s1_valid) begin
         cout <= gc[NG];
         ovf  <= ovf_d;
      end
   end

   // Nibble-top g/p only feed the group terms already captured in stage 1.
   assign unused_bits = ^top_gp;
`else
   assign cout = 1'b0;
   assign ovf  = 1'b0;

   assign unused_bits = ^{top_gp, gc[NG]};
`endif

endmodule

// File: tb/tb_cla_carry_sum_pipe.sv
// Self-checking bench for cla_carry_sum_pipe (WIDTH=32) against an arithmetic reference model.
module tb_cla_carry_sum_pipe;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_cmp;
   int n_err;

   cla_carry_sum_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed/unsigned integer arithmetic, no carry structure.
   function automatic res_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
      res_t   m;
      longint sa;
      longint sb;
      longint r;
      sa    = longint'($signed(ai));
      sb    = longint'($signed(bi));
      r     = si ? (sa - sb) : (sa + sb);
      m.sum = W'(r);
`ifdef CLA_FLAGS_EN
      m.cout = si ? (ai >= bi) : ((64'(ai) + 64'(bi)) > 64'hFFFF_FFFF);
      m.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      m.cout = 1'b0;
      m.ovf  = 1'b0;
`endif
      return m;
   endfunction

   // Drive one cycle's inputs on the falling edge, then let outputs settle.
   task automatic drive(input logic iv, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic si, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      a         = ai;
      b         = bi;
      sub       = si;
      out_ready = ordy;
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      n_cmp++;
      if (sum !== '0) begin
         n_err++; $display("FAIL reset_sum got=%h want=0", sum);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
      n_cmp++;
      if (cout !== 1'b0 || ovf !== 1'b0) begin
         n_err++; $display("FAIL reset_flags got=%b%b want=00", cout, ovf);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL idle_out_valid got=%b want=0", out_valid);
      end
   endtask

   task automatic test_reset_inflight;
      drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      drive(1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL inflight_full_in_ready got=%b want=0", in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL inflight_reset_out_valid got=%b want=0", out_valid);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL inflight_ghost cyc=%0d got=%b want=0 sum=%h", i, out_valid, sum);
         end
      end
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0005,
                               32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
      logic [W-1:0] tb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                               32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
      logic         ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] es [6] = '{32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
`ifdef CLA_FLAGS_EN
      logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic         eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
      logic         ec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic         eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, ta[i], tb[i], ts[i], 1'b1);
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL dir%0d_early got=%b want=0", i, out_valid);
         end
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL dir%0d_valid got=%b want=1", i, out_valid);
         end
         n_cmp++;
         if (sum !== es[i]) begin
            n_err++; $display("FAIL dir%0d_sum got=%h want=%h", i, sum, es[i]);
         end
         n_cmp++;
         if (cout !== ec[i]) begin
            n_err++; $display("FAIL dir%0d_cout got=%b want=%b", i, cout, ec[i]);
         end
         n_cmp++;
         if (ovf !== eo[i]) begin
            n_err++; $display("FAIL dir%0d_ovf got=%b want=%b", i, ovf, eo[i]);
         end
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure;
      int k;
      int got;
      int outstanding;
      logic ordy;
      logic exp_ready;
      logic [W-1:0] want;
      k = 1;
      got = 0;
      outstanding = 0;
      for (int cyc = 1; cyc <= 40 && got < 5; cyc++) begin
         ordy = !(cyc >= 3 && cyc <= 6);
         drive(k <= 5, W'(k), W'(16 * k), 1'b0, ordy);
         exp_ready = (outstanding < 2) || ordy;
         n_cmp++;
         if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready);
         end
         if (out_valid === 1'b1) begin
            want = W'(17 * (got + 1));
            n_cmp++;
            if (sum !== want) begin
               n_err++; $display("FAIL bp_sum cyc=%0d got=%h want=%h", cyc, sum, want);
            end
            if (ordy) begin
               got++;
               outstanding--;
            end
         end
         if (k <= 5 && in_ready === 1'b1) begin
            k++;
            outstanding++;
         end
      end
      n_cmp++;
      if (got !== 5) begin
         n_err++; $display("FAIL bp_count got=%0d want=5", got);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_extra got=%b want=0 sum=%h", out_valid, sum);
      end
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random;
      res_t q[$];
      res_t exp_r;
      logic iv;
      logic ordy;
      logic s;
      logic exp_ready;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      for (int cyc = 0; cyc < 10020; cyc++) begin
         iv   = (cyc < 10000) && ($urandom_range(0, 9) < 7);
         ordy = (cyc >= 10000) || ($urandom_range(0, 9) < 7);
         ra   = pick_operand();
         rb   = pick_operand();
         s    = 1'($urandom_range(0, 1));
         drive(iv, ra, rb, s, ordy);
         exp_ready = (q.size() < 2) || ordy;
         n_cmp++;
         if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready);
         end
         if (out_valid === 1'b1 && ordy) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL rnd_spurious cyc=%0d got=valid want=idle", cyc);
            end else begin
               exp_r = q.pop_front();
               if ({sum, cout, ovf} !== exp_r) begin
                  n_err++;
                  $display("FAIL rnd_result cyc=%0d got=%h/%b/%b want=%h/%b/%b",
                           cyc, sum, cout, ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
               end
            end
         end
         if (iv && in_ready === 1'b1) begin
            q.push_back(model(ra, rb, s));
         end
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL rnd_drain got=%0d pending want=0", q.size());
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      out_ready = 1'b0;
      test_reset;
      test_reset_inflight;
      test_directed;
      test_backpressure;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
